gb_oam_dma: RTL and testbench
=============================

// Module: gb_oam_dma
// PURPOSE
//  OAM DMA controller behind register 0xFF46. A CPU write of byte XX copies 160 bytes,
//  XX00..XX9F, from the external bus into OAM 0xFE00..0xFE9F.
//  It replaces the video board's DMA master and owns the external bus while active.
//  Top level muxes adr/read into adr_ext/rd_ext and gates CPU ext/VRAM/OAM reads with active.
// PARAMETERS
//  CYC_PER_BYTE   4    clocks per byte transferred (one M-cycle); legal range 2..15
//  START_DELAY    4    clocks from register write to the first bus cycle; legal range 1..15
//  OAM_LEN        160  number of bytes per transfer
// PORTS
//  clk        in   1   CPU clock (gbclk)
//  reset      in   1   synchronous, active-high
//  write      in   1   register write strobe, already qualified by the 0xFF46 select
//  din        in   8   CPU write data (source high byte)
//  dout       out  8   register readback: last value written
//  adr        out  16  external bus address while active, else 0
//  read       out  1   external read request
//  data_in    in   8   external bus read data, valid at the last phase of each byte
//  oam_adr    out  8   OAM byte index 0..159
//  oam_dout   out  8   byte to store in OAM
//  oam_write  out  1   OAM write strobe, one clock wide
//  active     out  1   high while state = XFER
//  done       out  1   one-clock pulse after the 160th OAM write is issued
// BEHAVIOUR
//  Reset: state IDLE; dout=0x00; adr=0; read=0; oam_adr=0; oam_dout=0; oam_write=0; active=0; done=0.
//  Reset wins over a write in the same clock and aborts any transfer immediately; no further oam_write.
//  Register: on write, src <= din, except din>=0xE0 maps to din-0x20 (echo of WRAM).
//   dout always returns the unmapped din.
//  FSM:
//   IDLE  --write--> START: load the delay counter with START_DELAY-1.
//   START: counts down; at 0 -> XFER with idx=0, phase=0.
//   XFER: adr={src,idx}; read=1 on every phase 0..CYC_PER_BYTE-1.
//    At the phase CYC_PER_BYTE-1 edge: oam_dout<=data_in, oam_adr<=idx, oam_write<=1 (for the next clock).
//    Then phase<=0 and idx<=idx+1.
//    After the edge with idx=OAM_LEN-1: -> IDLE, done<=1, read and adr drop to 0 in the same clock.
//  Latency: write sampled at edge E.
//   active rises after edge E+START_DELAY.
//   First oam_write is high during the clock after edge E+START_DELAY+CYC_PER_BYTE.
//   active is high for exactly OAM_LEN*CYC_PER_BYTE clocks (640 at defaults).
//  Restart: a write in START or XFER reloads src and returns to START with idx=0.
//   The in-flight byte is discarded and no oam_write is issued for it.
//   An oam_write already registered at that edge still completes.
//  A write in the same clock as the final byte's edge: that byte's oam_write is issued, done is NOT pulsed, state -> START.
//  idx is 8 bits; phase is 4 bits; neither wraps because the terminal compare is exact.
//  data_in is sampled only on the last phase; its value on other phases is don't-care.
// STRUCTURE
//  Shared package gb_dma_pkg:
//   state encoding {IDLE, START, XFER};
//   OAM_BASE=16'hFE00; DMA_REG=8'h46; ECHO_BASE=8'hE0; ECHO_OFS=8'h20.
//  Single module, no sub-modules.
//  Counters: idx (8b), phase (4b), delay (4b). All outputs are registered except adr, read and active.
// TESTING
//  1 Write 0xC1, memory model holds byte k = k^0x5A -> 160 oam_write pulses.
//    oam_adr 0..159 with oam_dout = k^0x5A; adr 0xC100..0xC19F; active 640 clocks; one done.
//  2 Write 0xE3 -> adr runs 0xC300..0xC39F; dout reads 0xE3.
//  3 Write 0x80, then write 0xD0 at byte 50 phase 2.
//    -> byte 50 is not written from 0x80; transfer restarts at 0xD000 after START_DELAY; idx restarts at 0.
//    -> exactly 210 oam_write pulses in total and one done.
//  4 Assert reset at byte 10 -> all outputs 0 next clock; no further oam_write; dout=0x00.
//  5 Write during START -> src reloaded; first adr uses the new value; START_DELAY restarts.
//  6 CYC_PER_BYTE=2, START_DELAY=1 -> active for 320 clocks, beginning 1 clock after the write.

Source files
------------

// File: rtl/gb_dma_pkg.sv
// Shared definitions for the Game Boy OAM DMA controller: FSM state
// encoding and the fixed addresses used around the 0xFF46 register.
package gb_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [7:0]  DMA_REG   = 8'h46;
  localparam logic [7:0]  ECHO_BASE = 8'hE0;
  localparam logic [7:0]  ECHO_OFS  = 8'h20;

endpackage

// File: rtl/gb_oam_dma.sv
// OAM DMA controller behind 0xFF46. A register write of XX copies the 160
// bytes XX00..XX9F from the external bus into OAM, one byte per
// CYC_PER_BYTE clocks, after a START_DELAY clock warm-up. The controller
// owns the external bus (adr/read) only while active.
import gb_dma_pkg::*;

module gb_oam_dma #(
  parameter int CYC_PER_BYTE = 4,
  parameter int START_DELAY  = 4,
  parameter int OAM_LEN      = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [15:0] adr,
  output logic        read,
  input  logic [7:0]  data_in,
  output logic [7:0]  oam_adr,
  output logic [7:0]  oam_dout,
  output logic        oam_write,
  output logic        active,
  output logic        done
);

  localparam logic [3:0] LAST_PHASE = 4'(CYC_PER_BYTE - 1);
  localparam logic [3:0] DELAY_LOAD = 4'(START_DELAY - 1);
  localparam logic [7:0] LAST_IDX   = 8'(OAM_LEN - 1);

  dma_state_t  state;
  logic [7:0]  src;
  logic [7:0]  idx;
  logic [3:0]  phase;
  logic [3:0]  delay;
  logic        byte_end;

  // Sources in echo RAM (0xE000..) alias work RAM 0x2000 lower.
  function automatic logic [7:0] map_src(input logic [7:0] v);
    return (v >= ECHO_BASE) ? (v - ECHO_OFS) : v;
  endfunction

  // The last phase of a byte is the edge at which data_in is captured.
  assign byte_end = (state == XFER) && (phase == LAST_PHASE);

  // Bus ownership follows the state directly so it drops the same clock the FSM leaves XFER.
  assign active = (state == XFER);
  assign read   = active;
  assign adr    = active ? {src, idx} : 16'h0000;

  // Register, counters, FSM and registered OAM-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src       <= 8'h00;
      dout      <= 8'h00;
      idx       <= 8'h00;
      phase     <= 4'h0;
      delay     <= 4'h0;
      oam_adr   <= 8'h00;
      oam_dout  <= 8'h00;
      oam_write <= 1'b0;
      done      <= 1'b0;
    end else begin
      oam_write <= 1'b0;
      done      <= 1'b0;

      // A byte whose capture edge coincides with a register write is still
      // stored; only bytes that have not reached their last phase are lost.
      if (byte_end) begin
        oam_dout  <= data_in;
        oam_adr   <= idx;
        oam_write <= 1'b1;
      end

      if (write) begin
        dout  <= din;
        src   <= map_src(din);
        state <= START;
        delay <= DELAY_LOAD;
        idx   <= 8'h00;
        phase <= 4'h0;
      end else begin
        case (state)
          IDLE: begin
            idx   <= 8'h00;
            phase <= 4'h0;
          end
          START: begin
            if (delay == 4'h0) begin
              state <= XFER;
              idx   <= 8'h00;
              phase <= 4'h0;
            end else begin
              delay <= delay - 4'h1;
            end
          end
          XFER: begin
            if (phase == LAST_PHASE) begin
              phase <= 4'h0;
              if (idx == LAST_IDX) begin
                state <= IDLE;
                idx   <= 8'h00;
                done  <= 1'b1;
              end else begin
                idx <= idx + 8'h01;
              end
            end else begin
              phase <= phase + 4'h1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gb_oam_dma.sv
// Scoreboard bench for gb_oam_dma: stimulus pushes expected OAM writes,
// a negedge monitor pops and compares them as the DUT issues oam_write.
import gb_dma_pkg::*;

module tb_gb_oam_dma;

  typedef struct packed {
    logic [7:0]  oadr;
    logic [7:0]  odat;
    logic [15:0] badr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_adr = 16'h0000;
  logic        write;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic [15:0] adr;
  logic        read;
  logic [7:0]  data_in;
  logic [7:0]  oam_adr;
  logic [7:0]  oam_dout;
  logic        oam_write;
  logic        active;
  logic        done;

  logic        write2 = 1'b0;
  logic [7:0]  din2 = 8'h00;
  logic [7:0]  dout2;
  logic [15:0] adr2;
  logic        read2;
  logic [7:0]  data_in2;
  logic [7:0]  oam_adr2;
  logic [7:0]  oam_dout2;
  logic        oam_write2;
  logic        active2;
  logic        done2;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int write_cyc = 0;

  exp_t sb[$];
  int   act_clk = 0, done_cnt = 0, wr_seen = 0, rise_cyc = 0;
  logic prev_act = 1'b0;
  logic [15:0] prev_adr = 16'h0000;
  int   act2 = 0, done_cnt2 = 0, wr2 = 0, rise2 = 0;
  logic prev_act2 = 1'b0;

  // External memory contents: page 0xC1 holds byte k = k^0x5A; other pages differ by page.
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC1);
  endfunction

  assign write    = cpu_we && (cpu_adr == {8'hFF, DMA_REG});
  assign data_in  = mem(adr);
  assign data_in2 = mem(adr2);

  gb_oam_dma dut (
    .clk(clk), .reset(reset), .write(write), .din(din), .dout(dout),
    .adr(adr), .read(read), .data_in(data_in), .oam_adr(oam_adr),
    .oam_dout(oam_dout), .oam_write(oam_write), .active(active), .done(done)
  );

  gb_oam_dma #(.CYC_PER_BYTE(2), .START_DELAY(1), .OAM_LEN(160)) dut2 (
    .clk(clk), .reset(reset), .write(write2), .din(din2), .dout(dout2),
    .adr(adr2), .read(read2), .data_in(data_in2), .oam_adr(oam_adr2),
    .oam_dout(oam_dout2), .oam_write(oam_write2), .active(active2), .done(done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor for the default instance: scoreboard pops plus activity counters.
  always @(negedge clk) begin
    exp_t e;
    if (active) act_clk++;
    if (active && !prev_act) rise_cyc = cyc;
    prev_act = active;
    if (done) done_cnt++;
    if (oam_write) begin
      wr_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_oam_write", {24'h0, oam_adr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("oam_adr", OAM_BASE + 16'(oam_adr), OAM_BASE + 16'(e.oadr));
        chk("oam_dout", {24'h0, oam_dout}, {24'h0, e.odat});
        chk("bus_adr", {16'h0, prev_adr}, {16'h0, e.badr});
      end
    end
    prev_adr = adr;
  end

  // Monitor for the fast instance (2 clocks per byte, 1 clock start delay).
  always @(negedge clk) begin
    if (active2) act2++;
    if (active2 && !prev_act2) rise2 = cyc;
    prev_act2 = active2;
    if (done2) done_cnt2++;
    if (oam_write2) wr2++;
  end

  task automatic push_xfer(input logic [7:0] page, input int first, input int last);
    exp_t e;
    for (int k = first; k <= last; k++) begin
      e.oadr = 8'(k);
      e.badr = {page, 8'(k)};
      e.odat = mem(e.badr);
      sb.push_back(e);
    end
  endtask

  task automatic do_write(input logic [7:0] d, input logic [15:0] a);
    @(negedge clk);
    cpu_we = 1'b1; cpu_adr = a; din = d;
    @(posedge clk);
    #1;
    write_cyc = cyc;
    cpu_we = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit);
    int n = 0;
    while (done_cnt == base && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk("done_within_budget", (done_cnt != base) ? 32'd1 : 32'd0, 32'd1);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int a0, d0, w0, n;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_dout", {24'h0, dout}, 32'h0);
    chk("rst_adr", {16'h0, adr}, 32'h0);
    chk("rst_read_act_done", {29'h0, read, active, done}, 32'h0);
    chk("rst_oam", {15'h0, oam_write, oam_adr, oam_dout}, 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Write to a different register must not start a transfer
    do_write(8'h55, 16'hFF47);
    repeat (8) @(posedge clk);
    #1;
    chk("other_reg_no_start", {31'h0, active}, 32'h0);
    chk("other_reg_dout", {24'h0, dout}, 32'h0);

    // Test 1: full transfer from 0xC100
    a0 = act_clk; d0 = done_cnt; w0 = wr_seen;
    push_xfer(8'hC1, 0, 159);
    do_write(8'hC1, {8'hFF, DMA_REG});
    n = 0;
    while (!oam_write && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("first_wr_latency", cyc - write_cyc, 32'd8);
    chk("rise_latency_1", rise_cyc - write_cyc, 32'd4);
    wait_done(d0, 800);
    chk("t1_active_clocks", act_clk - a0, 32'd640);
    chk("t1_done_count", done_cnt - d0, 32'd1);
    chk("t1_writes", wr_seen - w0, 32'd160);
    chk("t1_sb_empty", sb.size(), 32'd0);
    chk("t1_idle_adr", {15'h0, read, adr}, 32'h0);

    // Test 2: echo source 0xE3 maps to 0xC300, readback unmapped
    a0 = act_clk; d0 = done_cnt;
    push_xfer(8'hC3, 0, 159);
    do_write(8'hE3, {8'hFF, DMA_REG});
    chk("t2_dout", {24'h0, dout}, 32'hE3);
    wait_done(d0, 800);
    chk("t2_active_clocks", act_clk - a0, 32'd640);
    chk("t2_sb_empty", sb.size(), 32'd0);

    // Test 3: restart at byte 50 phase 2 with source 0xD0
    d0 = done_cnt; w0 = wr_seen;
    push_xfer(8'h80, 0, 49);
    do_write(8'h80, {8'hFF, DMA_REG});
    n = 0;
    while (wr_seen - w0 < 50 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("t3_reach_byte50", wr_seen - w0, 32'd50);
    @(negedge clk);
    push_xfer(8'hD0, 0, 159);
    do_write(8'hD0, {8'hFF, DMA_REG});
    chk("t3_src_readback", {24'h0, dout}, 32'hD0);
    wait_done(d0, 900);
    chk("t3_rise_latency", rise_cyc - write_cyc, 32'd4);
    chk("t3_writes", wr_seen - w0, 32'd210);
    chk("t3_done_count", done_cnt - d0, 32'd1);
    chk("t3_sb_empty", sb.size(), 32'd0);

    // Test 4: reset at byte 10 aborts the transfer
    w0 = wr_seen; d0 = done_cnt;
    push_xfer(8'hB0, 0, 9);
    do_write(8'hB0, {8'hFF, DMA_REG});
    n = 0;
    while (wr_seen - w0 < 10 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_dout", {24'h0, dout}, 32'h0);
    chk("t4_bus", {15'h0, read, adr}, 32'h0);
    chk("t4_flags", {30'h0, active, done}, 32'h0);
    chk("t4_oam", {15'h0, oam_write, oam_adr, oam_dout}, 32'h0);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    chk("t4_no_more_writes", wr_seen - w0, 32'd10);
    chk("t4_no_done", done_cnt - d0, 32'd0);
    chk("t4_sb_empty", sb.size(), 32'd0);

    // Test 5: write during START reloads source and restarts the delay
    a0 = act_clk; d0 = done_cnt;
    push_xfer(8'hA5, 0, 159);
    do_write(8'h90, {8'hFF, DMA_REG});
    do_write(8'hA5, {8'hFF, DMA_REG});
    wait_done(d0, 800);
    chk("t5_rise_latency", rise_cyc - write_cyc, 32'd4);
    chk("t5_active_clocks", act_clk - a0, 32'd640);
    chk("t5_sb_empty", sb.size(), 32'd0);

    // Test 6: fast instance, 2 clocks per byte, 1 clock start delay
    @(negedge clk);
    write2 = 1'b1; din2 = 8'hC2;
    @(posedge clk);
    #1;
    write_cyc = cyc;
    write2 = 1'b0;
    n = 0;
    while (done_cnt2 == 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    chk("t6_rise_latency", rise2 - write_cyc, 32'd1);
    chk("t6_active_clocks", act2, 32'd320);
    chk("t6_writes", wr2, 32'd160);
    chk("t6_done_count", done_cnt2, 32'd1);
    chk("t6_last_byte", {16'h0, oam_adr2, oam_dout2}, {16'h0, 8'd159, mem(16'hC29F)});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
